// File: rtl/frame_buffer_arbiter_if.sv
// Host write port and display-controller bundle for frame_buffer_arbiter.
// Optional macro FB_REPEAT_CNT_EN adds the RepeatCnt frame-repeat counter.
interface frame_buffer_arbiter_if #(
  parameter int unsigned ROW_W = 7,
  parameter int unsigned COL_W = 4
) ();

  // Host / display-controller driven
  logic                   CSDisplay;
  logic                   WrValid;
  logic [7:0]             WrData;
  logic                   SyncVB;

  // Arbiter driven
  logic                   WrReady;
  logic                   WE0;
  logic                   WE1;
  logic [ROW_W+COL_W-1:0] WrAddr;
  logic [7:0]             WrDataOut;
  logic                   RdSel;
  logic                   DispValid;
  logic                   Buf0Empty;
  logic                   Buf1Empty;
  logic                   SwapPulse;
  logic                   RepeatPulse;
`ifdef FB_REPEAT_CNT_EN
  logic [7:0]             RepeatCnt;
`endif

  // Host and display controller side
  modport master (
    output CSDisplay, WrValid, WrData, SyncVB,
    input  WrReady, WE0, WE1, WrAddr, WrDataOut, RdSel, DispValid,
    input  Buf0Empty, Buf1Empty, SwapPulse, RepeatPulse
`ifdef FB_REPEAT_CNT_EN
    , input RepeatCnt
`endif
  );

  // Arbiter side
  modport slave (
    input  CSDisplay, WrValid, WrData, SyncVB,
    output WrReady, WE0, WE1, WrAddr, WrDataOut, RdSel, DispValid,
    output Buf0Empty, Buf1Empty, SwapPulse, RepeatPulse
`ifdef FB_REPEAT_CNT_EN
    , output RepeatCnt
`endif
  );

endinterface

// File: rtl/frame_buffer_arbiter.sv
// Ping-pong frame buffer arbiter. Host bytes are steered into the buffer the
// display is not reading; a full buffer is handed to the display only on the
// SyncVB frame-start pulse. ROW_W/COL_W must cover ROWS/COLS.
// Optional macro FB_REPEAT_CNT_EN adds a saturating RepeatCnt output that
// counts frames re-shown since the last swap.
module frame_buffer_arbiter #(
  parameter int unsigned ROWS  = 100,
  parameter int unsigned COLS  = 16,
  parameter int unsigned ROW_W = 7,
  parameter int unsigned COL_W = 4
) (
  input logic clock,
  input logic reset,
  frame_buffer_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StFill, StWait} state_e;

  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);

  state_e                 r_state,      w_state_nxt;
  logic                   r_wr_sel,     w_wr_sel_nxt;
  logic                   r_rd_sel,     w_rd_sel_nxt;
  logic [ROW_W-1:0]       r_row,        w_row_nxt;
  logic [COL_W-1:0]       r_col,        w_col_nxt;
  logic                   r_we0,        w_we0_nxt;
  logic                   r_we1,        w_we1_nxt;
  logic [ROW_W+COL_W-1:0] r_wr_addr,    w_wr_addr_nxt;
  logic [7:0]             r_wr_data,    w_wr_data_nxt;
  logic                   r_disp_valid, w_disp_valid_nxt;
  logic                   r_buf0_empty, w_buf0_empty_nxt;
  logic                   r_buf1_empty, w_buf1_empty_nxt;
  logic                   r_swap,       w_swap_nxt;
  logic                   r_repeat,     w_repeat_nxt;
`ifdef FB_REPEAT_CNT_EN
  logic [7:0]             r_repeat_cnt, w_repeat_cnt_nxt;
`endif

  logic w_ready;
  logic w_xfer;
  logic w_last;

  assign w_ready = bus.CSDisplay & (r_state == StFill);
  assign w_xfer  = bus.WrValid & w_ready;
  assign w_last  = (r_row == LastRow) && (r_col == LastCol);

  // Next-state: write steering, address counters, buffer flags and swap FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_sel_nxt     = r_wr_sel;
    w_rd_sel_nxt     = r_rd_sel;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_we0_nxt        = 1'b0;
    w_we1_nxt        = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_disp_valid_nxt = r_disp_valid;
    w_buf0_empty_nxt = r_buf0_empty;
    w_buf1_empty_nxt = r_buf1_empty;
    w_swap_nxt       = 1'b0;
    w_repeat_nxt     = 1'b0;
`ifdef FB_REPEAT_CNT_EN
    w_repeat_cnt_nxt = r_repeat_cnt;
`endif

    // With CSDisplay low everything holds; strobes and pulses fall to 0
    if (bus.CSDisplay) begin
      if (w_xfer) begin
        w_we0_nxt     = ~r_wr_sel;
        w_we1_nxt     = r_wr_sel;
        w_wr_addr_nxt = {r_row, r_col};
        w_wr_data_nxt = bus.WrData;
        if (w_last) begin
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_state_nxt = StWait;
          if (r_wr_sel) w_buf1_empty_nxt = 1'b0;
          else          w_buf0_empty_nxt = 1'b0;
        end else if (r_col == LastCol) begin
          w_col_nxt = '0;
          w_row_nxt = r_row + 1'b1;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end

      if (bus.SyncVB) begin
        unique case (r_state)
          StWait: begin
            // Release the frame the display was showing before handing over
            if (r_disp_valid) begin
              if (r_rd_sel) w_buf1_empty_nxt = 1'b1;
              else          w_buf0_empty_nxt = 1'b1;
            end
            w_rd_sel_nxt     = r_wr_sel;
            w_wr_sel_nxt     = ~r_wr_sel;
            w_disp_valid_nxt = 1'b1;
            w_swap_nxt       = 1'b1;
            w_state_nxt      = StFill;
`ifdef FB_REPEAT_CNT_EN
            w_repeat_cnt_nxt = '0;
`endif
          end
          StFill: begin
            // Includes the case where the final byte lands this same cycle:
            // the swap waits for the next SyncVB
            if (r_disp_valid) begin
              w_repeat_nxt = 1'b1;
`ifdef FB_REPEAT_CNT_EN
              if (r_repeat_cnt != 8'hFF) w_repeat_cnt_nxt = r_repeat_cnt + 8'd1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State register with synchronous reset; reset drops any partial or full frame
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StFill;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_we0        <= 1'b0;
      r_we1        <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_disp_valid <= 1'b0;
      r_buf0_empty <= 1'b1;
      r_buf1_empty <= 1'b1;
      r_swap       <= 1'b0;
      r_repeat     <= 1'b0;
`ifdef FB_REPEAT_CNT_EN
      r_repeat_cnt <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_wr_sel     <= w_wr_sel_nxt;
      r_rd_sel     <= w_rd_sel_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_we0        <= w_we0_nxt;
      r_we1        <= w_we1_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_buf0_empty <= w_buf0_empty_nxt;
      r_buf1_empty <= w_buf1_empty_nxt;
      r_swap       <= w_swap_nxt;
      r_repeat     <= w_repeat_nxt;
`ifdef FB_REPEAT_CNT_EN
      r_repeat_cnt <= w_repeat_cnt_nxt;
`endif
    end
  end

  assign bus.WrReady     = w_ready;
  assign bus.WE0         = r_we0;
  assign bus.WE1         = r_we1;
  assign bus.WrAddr      = r_wr_addr;
  assign bus.WrDataOut   = r_wr_data;
  assign bus.RdSel       = r_rd_sel;
  assign bus.DispValid   = r_disp_valid;
  assign bus.Buf0Empty   = r_buf0_empty;
  assign bus.Buf1Empty   = r_buf1_empty;
  assign bus.SwapPulse   = r_swap;
  assign bus.RepeatPulse = r_repeat;
`ifdef FB_REPEAT_CNT_EN
  assign bus.RepeatCnt   = r_repeat_cnt;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed table-driven bench for frame_buffer_arbiter with ROWS=4, COLS=2.
module tb_frame_buffer_arbiter;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 2;
  localparam int unsigned ROW_W = 7;
  localparam int unsigned COL_W = 4;

  typedef struct packed {
    logic        we0;
    logic        we1;
    logic [10:0] addr;
    logic [7:0]  dout;
    logic        rdsel;
    logic        dv;
    logic        b0e;
    logic        b1e;
    logic        swp;
    logic        rep;
    logic        rdy;
  } out_t;

  typedef struct {
    logic       cs;
    logic       v;
    logic [7:0] d;
    logic       sv;
    out_t       exp;
    logic [7:0] cnt;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  frame_buffer_arbiter_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  frame_buffer_arbiter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t mko(logic we0, logic we1, int addr, int dout, logic rdsel,
                               logic dv, logic b0e, logic b1e, logic swp, logic rep,
                               logic rdy);
    out_t o;
    o.we0 = we0; o.we1 = we1; o.addr = 11'(addr); o.dout = 8'(dout);
    o.rdsel = rdsel; o.dv = dv; o.b0e = b0e; o.b1e = b1e;
    o.swp = swp; o.rep = rep; o.rdy = rdy;
    return o;
  endfunction

  task automatic add(logic cs, logic v, int d, logic sv, out_t exp, int cnt);
    vec_t r;
    r.cs = cs; r.v = v; r.d = 8'(d); r.sv = sv; r.exp = exp; r.cnt = 8'(cnt);
    vecs.push_back(r);
  endtask

  task automatic drive(logic cs, logic v, int d, logic sv);
    bus.CSDisplay = cs;
    bus.WrValid   = v;
    bus.WrData    = 8'(d);
    bus.SyncVB    = sv;
  endtask

  task automatic check(string name, out_t exp, logic [7:0] cnt);
    out_t act;
    act = mko(bus.WE0, bus.WE1, int'(bus.WrAddr), int'(bus.WrDataOut), bus.RdSel,
              bus.DispValid, bus.Buf0Empty, bus.Buf1Empty, bus.SwapPulse,
              bus.RepeatPulse, bus.WrReady);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got we0=%b we1=%b addr=%0d dout=%h rd=%b dv=%b b0e=%b b1e=%b sw=%b rp=%b rdy=%b | want we0=%b we1=%b addr=%0d dout=%h rd=%b dv=%b b0e=%b b1e=%b sw=%b rp=%b rdy=%b",
               name, act.we0, act.we1, act.addr, act.dout, act.rdsel, act.dv, act.b0e,
               act.b1e, act.swp, act.rep, act.rdy, exp.we0, exp.we1, exp.addr, exp.dout,
               exp.rdsel, exp.dv, exp.b0e, exp.b1e, exp.swp, exp.rep, exp.rdy);
    end
`ifdef FB_REPEAT_CNT_EN
    checks++;
    if (bus.RepeatCnt !== cnt) begin
      failures++;
      $display("FAIL %s.cnt: got %0d want %0d", name, bus.RepeatCnt, cnt);
    end
`else
    if (cnt != cnt) $display("unreachable");
`endif
  endtask

  task automatic step(logic cs, logic v, int d, logic sv);
    drive(cs, v, d, sv);
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b1, 1'b0, 0, 1'b0);

    // Fill Buf0: 0x10..0x17 back to back
    add(1,1,'h10,0, mko(1,0, 0,'h10,0,0,1,1,0,0,1), 0);
    add(1,1,'h11,0, mko(1,0, 1,'h11,0,0,1,1,0,0,1), 0);
    add(1,1,'h12,0, mko(1,0,16,'h12,0,0,1,1,0,0,1), 0);
    add(1,1,'h13,0, mko(1,0,17,'h13,0,0,1,1,0,0,1), 0);
    add(1,1,'h14,0, mko(1,0,32,'h14,0,0,1,1,0,0,1), 0);
    add(1,1,'h15,0, mko(1,0,33,'h15,0,0,1,1,0,0,1), 0);
    add(1,1,'h16,0, mko(1,0,48,'h16,0,0,1,1,0,0,1), 0);
    add(1,1,'h17,0, mko(1,0,49,'h17,0,0,0,1,0,0,0), 0);
    // WAIT: valid held but nothing accepted
    add(1,1,'h18,0, mko(0,0,49,'h17,0,0,0,1,0,0,0), 0);
    // First swap
    add(1,0,'h00,1, mko(0,0,49,'h17,0,1,0,1,1,0,1), 0);
    // Fill Buf1, repeat after 3 bytes
    add(1,1,'h20,0, mko(0,1, 0,'h20,0,1,0,1,0,0,1), 0);
    add(1,1,'h21,0, mko(0,1, 1,'h21,0,1,0,1,0,0,1), 0);
    add(1,1,'h22,0, mko(0,1,16,'h22,0,1,0,1,0,0,1), 0);
    add(1,0,'h00,1, mko(0,0,16,'h22,0,1,0,1,0,1,1), 1);
    add(1,1,'h23,0, mko(0,1,17,'h23,0,1,0,1,0,0,1), 1);
    add(1,1,'h24,0, mko(0,1,32,'h24,0,1,0,1,0,0,1), 1);
    add(1,1,'h25,0, mko(0,1,33,'h25,0,1,0,1,0,0,1), 1);
    add(1,1,'h26,0, mko(0,1,48,'h26,0,1,0,1,0,0,1), 1);
    // Final byte with SyncVB: no swap, repeat instead
    add(1,1,'h27,1, mko(0,1,49,'h27,0,1,0,0,0,1,0), 2);
    add(1,0,'h00,0, mko(0,0,49,'h27,0,1,0,0,0,0,0), 2);
    // Second swap
    add(1,0,'h00,1, mko(0,0,49,'h27,1,1,1,0,1,0,1), 0);
    add(1,1,'h30,0, mko(1,0, 0,'h30,1,1,1,0,0,0,1), 0);
    // Freeze for 5 cycles
    for (int i = 0; i < 5; i++) add(0,1,'h31,1, mko(0,0,0,'h30,1,1,1,0,0,0,0), 0);
    add(1,1,'h32,0, mko(1,0, 1,'h32,1,1,1,0,0,0,1), 0);

    // Reset state
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("reset", mko(0,0,0,0,0,0,1,1,0,0,1), 8'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].cs, vecs[i].v, int'(vecs[i].d), vecs[i].sv);
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cnt);
    end

    // Mid-frame reset after 5 bytes into Buf0
    step(1, 1, 'h33, 0);
    check("mid_b3", mko(1,0,16,'h33,1,1,1,0,0,0,1), 8'd0);
    step(1, 1, 'h34, 0);
    step(1, 1, 'h35, 0);
    check("mid_b5", mko(1,0,32,'h35,1,1,1,0,0,0,1), 8'd0);
    reset = 1'b1;
    step(1, 1, 'h36, 1);
    check("mid_reset", mko(0,0,0,0,0,0,1,1,0,0,1), 8'd0);
    reset = 1'b0;
    step(1, 1, 'h40, 0);
    check("post_reset_wr", mko(1,0,0,'h40,0,0,1,1,0,0,1), 8'd0);
    step(1, 0, 0, 1);
    check("post_reset_nosv", mko(0,0,0,'h40,0,0,1,1,0,0,1), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
